apb_timer_slave: RTL

APB slave peripheral that sits directly downstream of the AHB-to-APB bridge. It consumes the bridge's PSEL/PENABLE/PWRITE/PADDR/PWDATA and returns PRDATA during the access phase. Internally it is a four-register, memory-mapped down-counter timer with prescaler, auto-reload and a level interrupt. It gives the bridge a real APB target with side effects to exercise end to end.

---
 rtl/apb_timer_slave_if.sv | 25 ++
 rtl/apb_timer_slave.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/apb_timer_slave_if.sv
// apb_timer_slave_if: APB bus bundle between the AHB-to-APB bridge and apb_timer_slave.
//   master modport: drives PSEL/PENABLE/PWRITE/PADDR/PWDATA, receives PRDATA/PREADY/PSLVERR.
//   slave modport : the reverse.
// Clock and reset stay outside the interface as plain ports.
`timescale 1ns/1ps
interface apb_timer_slave_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_timer_slave.sv
// apb_timer_slave: APB target holding a prescaled 32-bit down-counter timer.
//   Registers (offset PADDR[3:2]): 0x0 CTRL {prescale[15:8], irq_en[2], auto_reload[1], en[0]},
//   0x4 LOAD, 0x8 COUNT (read-only), 0xC STATUS {expired[0]} write-1-to-clear.
// Ports:
//   HCLK      clock, all state on rising edge
//   HRESETn   synchronous reset, active HIGH despite the name
//   apb       APB slave modport (PSEL/PENABLE/PWRITE/PADDR/PWDATA in; PRDATA/PREADY/PSLVERR out)
//   TIMER_IRQ level interrupt = STATUS.expired & CTRL.irq_en
// Build option: define APB_WAIT_STATE_EN to insert one wait state (WAIT) before ACCESS.
`timescale 1ns/1ps
module apb_timer_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    apb_timer_slave_if.slave   apb,
    output logic               TIMER_IRQ
);

`ifdef APB_WAIT_STATE_EN
    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StWait} state_e;
`else
    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;
`endif

    state_e      state_q, state_d;
    logic        capture;

    // Transfer attributes captured on entry to ACCESS; the bus may already carry the
    // next transfer's setup phase while we sit in ACCESS.
    logic        hit_q, wr_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic [31:0] prdata_q;

    logic        en_q, en_d, auto_q, auto_d, irq_en_q, irq_en_d;
    logic [7:0]  prescale_q, prescale_d, presc_q, presc_d;
    logic [31:0] load_q, load_d, count_q, count_d;
    logic        expired_q, expired_d;

    logic        hit;
    logic [31:0] rd_mux;
    logic        wr_en, wr_ctrl, wr_load, wr_status;
    logic        tick, expire;
    logic        unused_paddr;

    assign unused_paddr = ^apb.PADDR[1:0];

    // FSM next state
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        unique case (state_q)
            StIdle:   if (apb.PSEL && !apb.PENABLE) state_d = StSetup;
            StSetup: begin
                if (apb.PSEL && apb.PENABLE) begin
`ifdef APB_WAIT_STATE_EN
                    state_d = StWait;
`else
                    state_d = StAccess;
                    capture = 1'b1;
`endif
                end else begin
                    state_d = StIdle;
                end
            end
`ifdef APB_WAIT_STATE_EN
            StWait: begin
                if (apb.PSEL && apb.PENABLE) begin
                    state_d = StAccess;
                    capture = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
`endif
            StAccess: state_d = (apb.PSEL && !apb.PENABLE) ? StSetup : StIdle;
            default:  state_d = StIdle;
        endcase
    end

    assign hit = (apb.PADDR[31:4] == BASE_ADDR[31:4]);

    always_comb begin
        rd_mux = 32'd0;
        unique case (apb.PADDR[3:2])
            2'd0: rd_mux = {16'd0, prescale_q, 5'd0, irq_en_q, auto_q, en_q};
            2'd1: rd_mux = load_q;
            2'd2: rd_mux = count_q;
            2'd3: rd_mux = {31'd0, expired_q};
            default: rd_mux = 32'd0;
        endcase
    end

    assign wr_en     = (state_q == StAccess) && wr_q && hit_q;
    assign wr_ctrl   = wr_en && (off_q == 2'd0);
    assign wr_load   = wr_en && (off_q == 2'd1);
    assign wr_status = wr_en && (off_q == 2'd3);

    assign tick   = en_q && (presc_q == prescale_q);
    assign expire = tick && (count_q == 32'd0);

    // Timer next state. Register writes take priority over the tick; an expiry still
    // latches STATUS even when a CTRL write discards the tick.
    always_comb begin
        en_d       = en_q;
        auto_d     = auto_q;
        irq_en_d   = irq_en_q;
        prescale_d = prescale_q;
        presc_d    = presc_q;
        load_d     = load_q;
        count_d    = count_q;

        if (wr_ctrl) begin
            en_d       = wdata_q[0];
            auto_d     = wdata_q[1];
            irq_en_d   = wdata_q[2];
            prescale_d = wdata_q[15:8];
            presc_d    = 8'd0;
        end else begin
            if (en_q) presc_d = tick ? 8'd0 : presc_q + 8'd1;
            if (expire && !auto_q) en_d = 1'b0;
        end

        if (wr_load) begin
            load_d  = wdata_q;
            count_d = wdata_q;
        end else if (tick && !wr_ctrl) begin
            if (count_q != 32'd0) count_d = count_q - 32'd1;
            else if (auto_q)      count_d = load_q;
        end

        // Set beats a simultaneous write-1-to-clear.
        expired_d = expire || (expired_q && !(wr_status && wdata_q[0]));
    end

    always_ff @(posedge HCLK) begin
        if (HRESETn) begin
            state_q    <= StIdle;
            hit_q      <= 1'b0;
            wr_q       <= 1'b0;
            off_q      <= 2'd0;
            wdata_q    <= 32'd0;
            prdata_q   <= 32'd0;
            en_q       <= 1'b0;
            auto_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            prescale_q <= 8'd0;
            presc_q    <= 8'd0;
            load_q     <= 32'd0;
            count_q    <= 32'd0;
            expired_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                hit_q    <= hit;
                wr_q     <= apb.PWRITE;
                off_q    <= apb.PADDR[3:2];
                wdata_q  <= apb.PWDATA;
                prdata_q <= hit ? rd_mux : 32'd0;
            end
            en_q       <= en_d;
            auto_q     <= auto_d;
            irq_en_q   <= irq_en_d;
            prescale_q <= prescale_d;
            presc_q    <= presc_d;
            load_q     <= load_d;
            count_q    <= count_d;
            expired_q  <= expired_d;
        end
    end

    assign apb.PRDATA  = prdata_q;
    assign apb.PREADY  = (state_q == StAccess);
    assign apb.PSLVERR = (state_q == StAccess) && !hit_q;
    assign TIMER_IRQ   = expired_q && irq_en_q;

endmodule
